// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and frame-buffer types.
package vga_pkg;

    // 1280x1024@60 timing; hcount/vcount run from the start of sync.
    localparam int HD = 1280;
    localparam int HF = 48;
    localparam int HR = 112;
    localparam int HB = 248;
    localparam int VD = 1024;
    localparam int VF = 1;
    localparam int VR = 3;
    localparam int VB = 38;
    localparam int HMAX = HR + HB + HD + HF;
    localparam int VMAX = VR + VB + VD + VF;

    localparam int FB_DEPTH = HD * VD;

    typedef logic [11:0] pixel_t;

    typedef enum logic [1:0] {
        ARB_DISP,
        ARB_HOST,
        ARB_IDLE
    } arb_state_t;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// rtl/vga_fb_addr_gen.sv - display slot decode, raster address counter and frame_start.
module vga_fb_addr_gen #(
    parameter int HD         = 1280,
    parameter int HR         = 112,
    parameter int HB         = 248,
    parameter int VD         = 1024,
    parameter int VR         = 3,
    parameter int VB         = 38,
    parameter int HSYNC_BITS = 11,
    parameter int VSYNC_BITS = 11,
    parameter int ADDR_W     = 21
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [HSYNC_BITS-1:0] hcount,
    input  logic [VSYNC_BITS-1:0] vcount,
    output logic                  disp_slot,
    output logic [ADDR_W-1:0]     slot_addr,
    output logic                  frame_start
);

    localparam logic [HSYNC_BITS-1:0] H_START = HSYNC_BITS'(HR + HB);
    localparam logic [HSYNC_BITS-1:0] H_END   = HSYNC_BITS'(HR + HB + HD);
    localparam logic [VSYNC_BITS-1:0] V_START = VSYNC_BITS'(VR + VB);
    localparam logic [VSYNC_BITS-1:0] V_END   = VSYNC_BITS'(VR + VB + VD);

    logic              first_slot;
    logic [ADDR_W-1:0] disp_addr;

    always_comb begin
        disp_slot  = (hcount >= H_START) && (hcount < H_END) &&
                     (vcount >= V_START) && (vcount < V_END);
        first_slot = disp_slot && (hcount == H_START) && (vcount == V_START);
        // The frame restart is folded into the slot address so the counter never needs to wrap.
        slot_addr  = first_slot ? '0 : disp_addr;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            disp_addr   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= first_slot;
            if (disp_slot) begin
                disp_addr <= slot_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one pixel RAM between VGA scan-out and a blanking-time host port.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int HD         = 1280,
    parameter int HR         = 112,
    parameter int HB         = 248,
    parameter int VD         = 1024,
    parameter int VR         = 3,
    parameter int VB         = 38,
    parameter int HSYNC_BITS = 11,
    parameter int VSYNC_BITS = 11,
    parameter int ADDR_W     = 21,
    parameter int PIX_W      = 12
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [HSYNC_BITS-1:0] hcount,
    input  logic [VSYNC_BITS-1:0] vcount,
    input  logic                  pixel_enable,
    input  logic                  host_valid,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [PIX_W-1:0]      host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [PIX_W-1:0]      host_rdata,
    output logic                  host_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [PIX_W-1:0]      mem_wdata,
    input  logic [PIX_W-1:0]      mem_rdata,
    output logic [PIX_W-1:0]      rgb,
    output logic                  frame_start
);

    // One extra bit so a frame buffer filling the whole address space still compares correctly.
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(HD * VD);

    logic              disp_slot;
    logic [ADDR_W-1:0] slot_addr;
    logic              in_range;
    arb_state_t        arb_state;
    logic              rd_oor;
    logic [PIX_W-1:0]  rdata_ret;
    logic [PIX_W-1:0]  rdata_hold;

    vga_fb_addr_gen #(
        .HD         (HD),
        .HR         (HR),
        .HB         (HB),
        .VD         (VD),
        .VR         (VR),
        .VB         (VB),
        .HSYNC_BITS (HSYNC_BITS),
        .VSYNC_BITS (VSYNC_BITS),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .arstn       (arstn),
        .hcount      (hcount),
        .vcount      (vcount),
        .disp_slot   (disp_slot),
        .slot_addr   (slot_addr),
        .frame_start (frame_start)
    );

    assign in_range = {1'b0, host_addr} < FB_LIMIT;

    always_comb begin
        arb_state = ARB_IDLE;
        if (disp_slot) begin
            arb_state = ARB_DISP;
        end else if (host_valid) begin
            arb_state = ARB_HOST;
        end

        host_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = slot_addr;
        mem_wdata  = host_wdata;
        case (arb_state)
            ARB_DISP: begin
                mem_en   = 1'b1;
                mem_addr = slot_addr;
            end
            ARB_HOST: begin
                host_ready = 1'b1;
                mem_en     = in_range;
                mem_we     = host_we & in_range;
                mem_addr   = host_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            host_rvalid <= 1'b0;
            rd_oor      <= 1'b0;
            host_err    <= 1'b0;
            rdata_hold  <= '0;
        end else begin
            host_rvalid <= host_ready & ~host_we;
            rd_oor      <= host_ready & ~host_we & ~in_range;
            host_err    <= host_ready & ~in_range;
            if (host_rvalid) begin
                rdata_hold <= rdata_ret;
            end
        end
    end

    // Read data passes straight through on the return cycle and is held afterwards.
    assign rdata_ret  = rd_oor ? '0 : mem_rdata;
    assign host_rdata = host_rvalid ? rdata_ret : rdata_hold;
    assign rgb        = pixel_enable ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed bench for vga_fb_arbiter on a tiny 8x4 raster.
module tb_vga_fb_arbiter;

    logic        clk;
    logic        arstn;
    logic [3:0]  hcount;
    logic [2:0]  vcount;
    logic        pixel_enable;
    logic        host_valid;
    logic        host_we;
    logic [5:0]  host_addr;
    logic [11:0] host_wdata;
    logic        host_ready;
    logic        host_rvalid;
    logic [11:0] host_rdata;
    logic        host_err;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] rgb;
    logic        frame_start;

    logic        prefill;
    logic [11:0] ram [64];
    logic [11:0] exp_pix [32];
    int          checks;
    int          errors;

    vga_fb_arbiter #(
        .HD(8), .HR(2), .HB(2), .VD(4), .VR(1), .VB(1),
        .HSYNC_BITS(4), .VSYNC_BITS(3), .ADDR_W(6), .PIX_W(12)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .hcount       (hcount),
        .vcount       (vcount),
        .pixel_enable (pixel_enable),
        .host_valid   (host_valid),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ready   (host_ready),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .host_err     (host_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .rgb          (rgb),
        .frame_start  (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic slot_at(input logic [3:0] h, input logic [2:0] v);
        return (h >= 4'd4) && (h < 4'd12) && (v >= 3'd2) && (v < 3'd6);
    endfunction

    // Free-running timing generator: 14 clocks per line, 7 lines per frame.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hcount       <= '0;
            vcount       <= '0;
            pixel_enable <= 1'b0;
        end else begin
            pixel_enable <= slot_at(hcount, vcount);
            if (hcount == 4'd13) begin
                hcount <= '0;
                vcount <= (vcount == 3'd6) ? 3'd0 : vcount + 3'd1;
            end else begin
                hcount <= hcount + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 64; i++) ram[i] <= 12'(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input int h, input int v, input string tag);
        int n;
        n = 0;
        step();
        while (!(int'(hcount) == h && int'(vcount) == v) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s wait_for(%0d,%0d) timed out: got h=%0d v=%0d", tag, h, v, hcount, vcount);
        end
    endtask

    task automatic scan_frame(input string tag);
        int idx;
        int n;
        wait_for(4, 2, tag);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 6'd0) begin
            errors++;
            $display("FAIL %s first_slot: mem_en=%b mem_addr=%0d, want 1/0", tag, mem_en, mem_addr);
        end
        step();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_start: got %b want 1", tag, frame_start);
        end
        idx = 0;
        n = 0;
        while (idx < 32 && n < 120) begin
            checks++;
            if (pixel_enable) begin
                if (rgb !== exp_pix[idx]) begin
                    errors++;
                    $display("FAIL %s pixel %0d: rgb=%h want %h", tag, idx, rgb, exp_pix[idx]);
                end
                idx++;
            end else if (rgb !== 12'h000) begin
                errors++;
                $display("FAIL %s blank rgb: got %h want 000", tag, rgb);
            end
            if (idx < 32) step();
            n++;
        end
        checks++;
        if (idx != 32) begin
            errors++;
            $display("FAIL %s pixel count: got %0d want 32", tag, idx);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (frame_start !== 1'b0 || host_rvalid !== 1'b0 || host_err !== 1'b0 ||
            host_rdata !== 12'h000 || rgb !== 12'h000 || mem_en !== 1'b0 || host_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: fs=%b rv=%b err=%b rdata=%h rgb=%h en=%b rdy=%b want all 0",
                     frame_start, host_rvalid, host_err, host_rdata, rgb, mem_en, host_ready);
        end
        @(negedge clk);
        arstn   = 1'b1;
        prefill = 1'b0;
    endtask

    task automatic test_scanout();
        scan_frame("scanout");
    endtask

    task automatic test_frame_count();
        int cnt;
        cnt = 0;
        for (int c = 0; c < 98; c++) begin
            step();
            if (frame_start === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL frame_start_count: got %0d want 1", cnt);
        end
    endtask

    task automatic test_host_write();
        wait_for(0, 0, "host_write");
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 6'd5;
        host_wdata = 12'hABC;
        #1;
        checks++;
        if (host_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== 6'd5 || mem_wdata !== 12'hABC) begin
            errors++;
            $display("FAIL host_write_accept: rdy=%b en=%b we=%b addr=%0d wdata=%h want 1/1/1/5/abc",
                     host_ready, mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        host_valid = 1'b0;
        checks++;
        if (host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL host_write_rvalid: got %b want 0", host_rvalid);
        end
        exp_pix[5] = 12'hABC;
        scan_frame("after_write");
    endtask

    task automatic test_host_stall();
        int n;
        wait_for(4, 3, "stall");
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = 6'd9;
        #1;
        n = 0;
        while (host_ready !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL stall_cycles: got %0d want 8", n);
        end
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd9) begin
            errors++;
            $display("FAIL stall_accept: en=%b we=%b addr=%0d want 1/0/9", mem_en, mem_we, mem_addr);
        end
        step();
        host_valid = 1'b0;
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 12'd9 || host_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_return: rvalid=%b rdata=%h err=%b want 1/009/0", host_rvalid, host_rdata, host_err);
        end
        step();
        checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== 12'd9) begin
            errors++;
            $display("FAIL stall_hold: rvalid=%b rdata=%h want 0/009", host_rvalid, host_rdata);
        end
    endtask

    task automatic test_out_of_range();
        wait_for(0, 4, "oor");
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = 6'd32;
        #1;
        checks++;
        if (host_ready !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_read_accept: rdy=%b en=%b want 1/0", host_ready, mem_en);
        end
        step();
        checks++;
        if (host_err !== 1'b1 || host_rvalid !== 1'b1 || host_rdata !== 12'h000) begin
            errors++;
            $display("FAIL oor_read_return: err=%b rvalid=%b rdata=%h want 1/1/000", host_err, host_rvalid, host_rdata);
        end
        host_we   = 1'b1;
        host_addr = 6'd40;
        host_wdata = 12'h555;
        #1;
        checks++;
        if (host_ready !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_write_accept: rdy=%b en=%b want 1/0", host_ready, mem_en);
        end
        step();
        host_valid = 1'b0;
        checks++;
        if (host_err !== 1'b1 || host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL oor_write_err: err=%b rvalid=%b want 1/0", host_err, host_rvalid);
        end
        step();
        checks++;
        if (host_err !== 1'b0 || host_rdata !== 12'h000) begin
            errors++;
            $display("FAIL oor_err_pulse: err=%b rdata=%h want 0/000", host_err, host_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int disp_idx;
        wait_for(0, 6, "b2b");
        k = 0;
        disp_idx = 0;
        for (int c = 0; c < 56; c++) begin
            if (c > 0) step();
            host_valid = 1'b1;
            host_we    = 1'b1;
            host_addr  = 6'(16 + (k % 16));
            host_wdata = 12'h300 | 12'(16 + (k % 16));
            #1;
            checks++;
            if (slot_at(hcount, vcount)) begin
                if (host_ready !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 6'(disp_idx)) begin
                    errors++;
                    $display("FAIL b2b_disp_slot: rdy=%b we=%b en=%b addr=%0d want 0/0/1/%0d",
                             host_ready, mem_we, mem_en, mem_addr, disp_idx);
                end
                disp_idx++;
            end else begin
                if (host_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== host_addr) begin
                    errors++;
                    $display("FAIL b2b_accept: rdy=%b we=%b addr=%0d want 1/1/%0d",
                             host_ready, mem_we, mem_addr, host_addr);
                end
                k++;
            end
        end
        step();
        host_valid = 1'b0;
        checks++;
        if (k != 48 || disp_idx != 8) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d slots=%0d want 48/8", k, disp_idx);
        end
        for (int a = 16; a < 32; a++) exp_pix[a] = 12'h300 | 12'(a);
        scan_frame("after_b2b");
    endtask

    task automatic test_reset_mid_frame();
        wait_for(0, 4, "rst_read");
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = 6'd7;
        step();
        host_valid = 1'b0;
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 12'd7) begin
            errors++;
            $display("FAIL rst_preread: rvalid=%b rdata=%h want 1/007", host_rvalid, host_rdata);
        end
        wait_for(6, 4, "rst_mid");
        arstn = 1'b0;
        #1;
        checks++;
        if (frame_start !== 1'b0 || host_rvalid !== 1'b0 || host_err !== 1'b0 ||
            host_rdata !== 12'h000 || rgb !== 12'h000 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: fs=%b rv=%b err=%b rdata=%h rgb=%h en=%b want all 0",
                     frame_start, host_rvalid, host_err, host_rdata, rgb, mem_en);
        end
        repeat (2) step();
        @(negedge clk);
        arstn = 1'b1;
        scan_frame("after_reset");
    endtask

    initial begin
        arstn      = 1'b0;
        prefill    = 1'b1;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        checks     = 0;
        errors     = 0;
        for (int i = 0; i < 32; i++) exp_pix[i] = 12'(i);

        test_reset();
        test_scanout();
        test_frame_count();
        test_host_write();
        test_host_stall();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Frame-buffer arbiter and scan-out sequencer that shares one single-port synchronous pixel RAM between the VGA display path and a host requester. It sits between the VGA timing generator, whose `hcount`, `vcount` and `pixel_enable` it consumes, the pixel RAM, and the RGB output pins. The display path owns the RAM on every active-area cycle. Host reads and writes are granted only during blanking, through a valid/ready handshake.

## Interface
Parameters:
- `HD`, default 1280: active pixels per line.
- `HR`, default 112: horizontal sync width, in pixels.
- `HB`, default 248: horizontal back porch, in pixels.
- `VD`, default 1024: active lines.
- `VR`, default 3: vertical sync width, in lines.
- `VB`, default 38: vertical back porch, in lines.
- `HSYNC_BITS`, default 11: `hcount` width.
- `VSYNC_BITS`, default 11: `vcount` width.
- `ADDR_W`, default 21: RAM address width. Must satisfy 2^ADDR_W ≥ HD·VD.
- `PIX_W`, default 12: pixel width, 4:4:4 RGB.

Ports:
- `clk`, in, 1: pixel clock.
- `arstn`, in, 1: reset, asynchronous, active-low.
- `hcount`, in, HSYNC_BITS: horizontal count from the timing generator.
- `vcount`, in, VSYNC_BITS: vertical count from the timing generator.
- `pixel_enable`, in, 1: registered active-area flag from the timing generator.
- `host_valid`, in, 1: host request valid.
- `host_we`, in, 1: 1 = write, 0 = read.
- `host_addr`, in, ADDR_W: host pixel address.
- `host_wdata`, in, PIX_W: host write data.
- `host_ready`, out, 1: host request accepted this cycle.
- `host_rvalid`, out, 1: host read data valid.
- `host_rdata`, out, PIX_W: host read data.
- `host_err`, out, 1: one-cycle pulse when an out-of-range request is accepted.
- `mem_en`, out, 1: RAM enable.
- `mem_we`, out, 1: RAM write enable.
- `mem_addr`, out, ADDR_W: RAM address.
- `mem_wdata`, out, PIX_W: RAM write data.
- `mem_rdata`, in, PIX_W: RAM read data. Valid one cycle after `mem_en` with `mem_we` = 0.
- `rgb`, out, PIX_W: pixel output to the DAC.
- `frame_start`, out, 1: one-cycle pulse on the first display slot of each frame.

## Operation
- Display slot (combinational on the inputs): `disp_slot` = (HR+HB ≤ hcount < HR+HB+HD) and (VR+VB ≤ vcount < VR+VB+VD).
- Display address counter `disp_addr`:
  - Cleared to 0 on reset.
  - Cleared when `frame_start` would fire.
  - Otherwise increments by 1 on each `disp_slot` cycle.
  - Produces linear raster order. No multiplier.
  - The address driven in a slot is the current `disp_addr` value, or 0 on the first slot of a frame.
- Arbitration states: DISP, HOST, IDLE, selected combinationally each cycle.
  - **DISP** (`disp_slot` = 1): `mem_en` = 1, `mem_we` = 0, `mem_addr` = display address, `host_ready` = 0. The display always wins.
  - **HOST** (`disp_slot` = 0 and `host_valid` = 1): `host_ready` = 1. Drive `mem_en` = 1 (forced to 0 if out of range), `mem_we` = `host_we`, `mem_addr` = `host_addr`, `mem_wdata` = `host_wdata`.
  - **IDLE**: `mem_en` = 0.
- Host handshake rules:
  - The host holds `host_valid`, `host_we`, `host_addr` and `host_wdata` stable until `host_ready`.
  - Exactly one transfer per cycle with `host_valid` & `host_ready`.
  - `host_ready` never asserts without `host_valid`.
- Out-of-range request (`host_addr` ≥ HD·VD):
  - Accepted (`host_ready` = 1) with no RAM access.
  - `host_err` pulses the next cycle.
  - For a read, `host_rvalid` still pulses, with `host_rdata` = 0.
- Read return: a display read in cycle N delivers `mem_rdata` in cycle N+1, which aligns with `pixel_enable`. Output `rgb` = `pixel_enable` ? `mem_rdata` : 0.
- Host read accepted in cycle N:
  - `host_rvalid` = 1 in cycle N+1.
  - `host_rdata` = `mem_rdata` in cycle N+1, then held until the next host read return.
- Reset values:
  - `disp_addr` = 0.
  - `host_rvalid`, `host_err`, `frame_start` = 0.
  - `host_rdata` = 0.
  - `rgb` = 0 whenever `pixel_enable` = 0.
- Reset mid-frame: all state clears. The timing generator shares `arstn`, so scan-out restarts at `disp_addr` 0 with no host transfer lost silently. A request that was not yet accepted must be re-presented by the host.

## Timing
- `frame_start` is registered and fires in the cycle after the slot where hcount = HR+HB and vcount = VR+VB.
- Display read latency to `rgb` is 1 cycle.
- Host read latency is 1 cycle after acceptance. Host write completes in the acceptance cycle.
- Host worst-case wait is one full active line, HD cycles, except across vertical blanking when none is needed.
- A host request arriving in the first display slot of a line stalls with `host_ready` = 0 until hcount ≥ HR+HB+HD.
- `disp_addr` wraps to 0 only via the frame clear, never by overflow.

## Structure
- Shared package `vga_pkg`:
  - Timing localparams: HD, HF, HR, HB, VD, VF, VR, VB, HMAX, VMAX.
  - `pixel_t` = logic [11:0].
  - FB_DEPTH = HD·VD.
- Sub-module `vga_fb_addr_gen` contains the `disp_slot` decode, the `disp_addr` counter and `frame_start`.

## Test plan
Simulation parameters: HD=8, HR=2, HB=2, VD=4, VR=1, VB=1, free-running timing generator.
1. Prefill RAM[i] = i. After reset → `rgb` shows 0,1,…,7 on line 0, then 8…15 on line 1. `frame_start` pulses once per frame, and `disp_addr` returns to 0 at the next frame.
2. Host write addr 5, data 0xABC during blanking → `host_ready` = 1 the same cycle. On the next frame, the 6th active pixel shows `rgb` = 0xABC.
3. Host read asserted at hcount = 4, the first active slot → `host_ready` stays 0 for 8 cycles, then asserts. `host_rvalid` follows 1 cycle later with the correct data.
4. Host request to addr 32 (≥ 8·4) → accepted, `mem_en` = 0, `host_err` pulses once, and for a read `host_rdata` = 0.
5. Back-to-back host writes throughout vertical blanking → one accept per cycle, no display slot lost, and `mem_we` is never 1 during a `disp_slot`.
6. Assert `arstn` = 0 mid-line 2 → all outputs reach reset values immediately. After release, the first frame starts at `disp_addr` 0.
